// File: rtl/even_odd.sv
// Serial parity tracker: a four-state Moore FSM that records the parity of 0s and 1s seen since reset.
// Optional saturating symbol counters are added when EVEN_ODD_COUNT_EN is defined.
module even_odd #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
`ifdef EVEN_ODD_COUNT_EN
   output logic [CNT_W-1:0] zero_cnt,
   output logic [CNT_W-1:0] one_cnt,
`endif
   output logic [1:0]       out
);

   // The state encoding is the output value: bit 1 is zero-parity, bit 0 is one-parity.
   typedef enum logic [1:0] {
      S00 = 2'b00,
      S01 = 2'b01,
      S10 = 2'b10,
      S11 = 2'b11
   } state_e;

   state_e state_q, state_d;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("even_odd: CNT_W must be >= 1");
   end

   // NOTE: each branch sets state_d, and the default covers any other value, so no latch is inferred.
   always_comb begin
      state_d = S00;
      case (state_q)
         S00:     state_d = in ? S01 : S10;
         S01:     state_d = in ? S00 : S11;
         S10:     state_d = in ? S11 : S00;
         S11:     state_d = in ? S10 : S01;
         default: state_d = S00;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S00;
      end else begin
         state_q <= state_d;
      end
   end

   assign out = state_q;

`ifdef EVEN_ODD_COUNT_EN
   logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
   logic [CNT_W-1:0] one_cnt_q,  one_cnt_d;

   // Counters stop at all-ones rather than wrapping; parity keeps toggling regardless.
   always_comb begin
      zero_cnt_d = zero_cnt_q;
      one_cnt_d  = one_cnt_q;
      if (!in && (zero_cnt_q != '1)) zero_cnt_d = zero_cnt_q + CNT_W'(1);
      if ( in && (one_cnt_q  != '1)) one_cnt_d  = one_cnt_q  + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         zero_cnt_q <= '0;
         one_cnt_q  <= '0;
      end else begin
         zero_cnt_q <= zero_cnt_d;
         one_cnt_q  <= one_cnt_d;
      end
   end

   assign zero_cnt = zero_cnt_q;
   assign one_cnt  = one_cnt_q;
`endif

endmodule

// File: tb/tb_even_odd.sv
// Self-checking bench for even_odd: symbol-count model checked every cycle plus directed literal vectors.
// Counter checks are included when EVEN_ODD_COUNT_EN is defined.
module tb_even_odd;

   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic       clk;
   logic       rst;
   logic       in;
   logic [1:0] out;
`ifdef EVEN_ODD_COUNT_EN
   logic [CNT_W-1:0] zero_cnt;
   logic [CNT_W-1:0] one_cnt;
`endif

   even_odd #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in),
`ifdef EVEN_ODD_COUNT_EN
      .zero_cnt (zero_cnt),
      .one_cnt  (one_cnt),
`endif
      .out      (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: plain counts of each symbol since the last reset edge.
   int   zeros       = 0;
   int   ones        = 0;
   logic model_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic i);
      rst = r;
      in  = i;
      @(posedge clk);
      if (!r) begin
         zeros = 0;
         ones  = 0;
      end else if (i) begin
         ones++;
      end else begin
         zeros++;
      end
      model_valid = 1'b1;
      #1;
   endtask

   task automatic step_exp(input logic r, input logic i, input logic [1:0] e);
      step(r, i);
      check("directed_out", {30'b0, out}, {30'b0, e});
   endtask

   // Compare process: parity is the count modulo two, counters are the count clipped at the maximum.
   logic [1:0] exp_out;
   always @(negedge clk) begin
      if (model_valid) begin
         exp_out = {((zeros % 2) == 1), ((ones % 2) == 1)};
         check("model_out", {30'b0, out}, {30'b0, exp_out});
`ifdef EVEN_ODD_COUNT_EN
         check("model_zero_cnt", 32'(zero_cnt), 32'((zeros > CNT_MAX) ? CNT_MAX : zeros));
         check("model_one_cnt",  32'(one_cnt),  32'((ones  > CNT_MAX) ? CNT_MAX : ones));
`endif
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "timeout");
   end

   logic [7:0] main_in  = 8'b0110_0111;
   logic [1:0] main_exp [8] = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
   logic [1:0] held;
   logic       rbit;

   initial begin
      rst = 1'b0;
      in  = 1'b0;
      @(negedge clk);

      // Reset held for two edges with the input toggling.
      step_exp(1'b0, 1'b0, 2'b00);
      step_exp(1'b0, 1'b1, 2'b00);
`ifdef EVEN_ODD_COUNT_EN
      check("reset_zero_cnt", 32'(zero_cnt), 32'd0);
      check("reset_one_cnt",  32'(one_cnt),  32'd0);
`endif

      // Main sequence 0,1,1,0,0,1,1,1 (first symbol is the MSB of main_in).
      for (int k = 0; k < 8; k++) begin
         step_exp(1'b1, main_in[7-k], main_exp[k]);
      end

      // A reset pulse that rises and falls between edges must not disturb the state.
      held = out;
      rst  = 1'b0;
      #2;
      rst  = 1'b1;
      #1;
      check("async_rst_ignored", {30'b0, out}, {30'b0, held});

      // Reset mid-stream from S11, then the first symbol counts as #1.
      step_exp(1'b0, 1'b1, 2'b00);
      step_exp(1'b1, 1'b1, 2'b01);

      // Eight 1s from S00, then three 0s.
      step_exp(1'b0, 1'b0, 2'b00);
      for (int k = 0; k < 8; k++) begin
         step_exp(1'b1, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b00);
      end
      step_exp(1'b1, 1'b0, 2'b10);
      step_exp(1'b1, 1'b0, 2'b00);
      step_exp(1'b1, 1'b0, 2'b10);

`ifdef EVEN_ODD_COUNT_EN
      // Five 0s saturate a 2-bit counter at 3 while zero-parity keeps toggling.
      step_exp(1'b0, 1'b0, 2'b00);
      step_exp(1'b1, 1'b0, 2'b10);
      check("sat_zero_cnt_1", 32'(zero_cnt), 32'd1);
      step_exp(1'b1, 1'b0, 2'b00);
      check("sat_zero_cnt_2", 32'(zero_cnt), 32'd2);
      step_exp(1'b1, 1'b0, 2'b10);
      check("sat_zero_cnt_3", 32'(zero_cnt), 32'd3);
      step_exp(1'b1, 1'b0, 2'b00);
      check("sat_zero_cnt_4", 32'(zero_cnt), 32'd3);
      step_exp(1'b1, 1'b0, 2'b10);
      check("sat_zero_cnt_5", 32'(zero_cnt), 32'd3);
      check("sat_one_cnt",    32'(one_cnt),  32'd0);
`endif

      // Random stream with occasional resets, checked by the compare process.
      for (int k = 0; k < 1000; k++) begin
         rbit = 1'($urandom_range(0, 1));
         step(($urandom_range(0, 99) != 0), rbit);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
